fetch_pipe: RTL and testbench
=============================

# fetch_pipe

Parametrised Y86-64 fetch stage for the pipelined processor, successor to the single-cycle fetch unit. Holds a loadable byte-addressed instruction memory, selects the fetch PC (predicted, or redirected from later stages), decodes and validates the instruction, predicts the next PC and latches the result into a stallable/bubble-able F/D pipeline register. A halt state machine stops fetch after a non-AOK instruction and recovers on redirect.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes; legal addresses 0..IMEM_BYTES-1.
- RESET_PC, 64'd0: predicted PC after reset.
- BIG_ENDIAN_IMM, 1: 1 = first immediate byte is MSB (legacy image format); 0 = little-endian (standard Y86).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hold pred_pc and F/D register.
- bubble_i  in  1  load bubble into F/D; hold pred_pc.
- redirect_valid  in  1  fetch from redirect_pc this cycle.
- redirect_pc  in  64  corrected PC (mispredicted jxx, ret target).
- ld_en  in  1  instruction-memory byte write.
- ld_addr  in  $clog2(IMEM_BYTES)  write address.
- ld_data  in  8  write byte.
- d_valid  out  1  F/D holds a real instruction.
- d_stat  out  3  1 AOK, 2 HLT, 3 ADR, 4 INS.
- d_icode, d_ifun, d_rA, d_rB  out  4 each  decoded fields.
- d_valC, d_valP, d_pc  out  64 each  constant, fall-through PC, instruction PC.
- pred_pc  out  64  predicted-PC register.
- halted  out  1  halt state machine in HALTED.

## Operation
- f_pc = redirect_valid ? redirect_pc : pred_pc.
- Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; invalid icode -> 1.
- valP = f_pc + length, 64-bit modular.
- ADR: any byte f_pc..f_pc+length-1 outside memory (f_pc >= IMEM_BYTES, or f_pc > IMEM_BYTES-length, or f_pc+length wraps). Forces icode 1, ifun 0, rA/rB F, valC 0.
- INS (when not ADR): icode > 0xB; or ifun > 3 for icode 6; ifun > 6 for icode 2/7; ifun != 0 for any other icode. Fields latched as fetched.
- HLT: icode 0, ifun 0, in range.
- rA/rB = byte1 nibbles only for icodes 2,3,4,5,6,A,B; otherwise 0xF. valC = bytes 2..9 (icode 3,4,5) or 1..8 (7,8), ordered per BIG_ENDIAN_IMM; otherwise 0.
- Prediction: next = valC for icode 7,8 with stat AOK; else valP.
- Memory write: ld_en writes mem[ld_addr] at posedge; reads combinational, new byte visible from next cycle. Memory unaffected by reset.
- Control priority per cycle: reset > redirect_valid > bubble_i > stall_i > normal.
  - normal/redirect: F/D <= fetched (d_valid 1); pred_pc <= prediction, except pred_pc holds when stat != AOK.
  - bubble_i: F/D <= bubble; pred_pc holds.
  - stall_i: F/D and pred_pc hold.
- Bubble value = reset value of F/D: d_valid 0, d_stat 1, d_icode 1, d_ifun 0, d_rA/d_rB F, d_valC/d_valP/d_pc 0.
- Halt FSM: RUN -> HALTED when a non-AOK instruction is latched (normal path). HALTED: F/D loads bubbles, pred_pc holds, stall_i/bubble_i ignored. HALTED -> RUN only on redirect_valid, which fetches and latches from redirect_pc that cycle (wrong-path halt squashed). Redirect in RUN never changes state unless the redirected fetch is non-AOK.

## Timing
- Reset: F/D = bubble value, pred_pc = RESET_PC, halted 0, FSM RUN.
- Fetch-to-D latency 1 cycle: instruction at f_pc in cycle N on d_* after edge N.
- Sustained 1 instruction/cycle with no stall/bubble.
- Redirect takes effect same cycle (zero-penalty at fetch); redirect wins over simultaneous stall/bubble.
- ld_en and fetch of same byte in one cycle: fetch sees old byte.
- reset asserted mid-halt or mid-stall: full reset next edge, memory retained.

## Test plan
- Load at 0: 60 23, 10, 00; run from reset -> D: (6,0,2,3,valP 2), (1,0,F,F,valP 3), (0,0, stat 2), then halted 1, pred_pc stays 3, d_valid 0.
- irmovq at 0: 30 F2 00..00 11, BIG_ENDIAN_IMM 1 -> d_valC 0x11, rB 2, valP 10; same bytes with BIG_ENDIAN_IMM 0 -> d_valC 0x1100000000000000.
- jxx at 0: 70 + dest 0x20, BIG_ENDIAN_IMM 1 -> d_valP 9, pred_pc 0x20; next cycle redirect_pc 9 -> d_pc 9, pred_pc from that instruction.
- IMEM_BYTES 1024, irmovq at 1020 -> d_stat 3, icode 1, halted 1; redirect_pc 0 -> halted 0, d_pc 0.
- Bytes 63 01 (OPq ifun 3, fine) and 67 01 -> stats 1 then 4; C0 -> stat 4, valP pc+1.
- stall_i 2 cycles mid-stream -> d_* and pred_pc frozen; bubble_i 1 cycle -> d_valid 0, pred_pc unchanged, same instruction re-fetched next cycle.

Source files
------------

// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if: the fetch stage's control, memory-load and F/D bus.
//   stall_i/bubble_i/redirect_*  : pipeline control into fetch
//   ld_en/ld_addr/ld_data        : instruction-memory byte load
//   d_*                          : F/D pipeline register contents
//   pred_pc, halted              : predicted-PC register, halt FSM state
// master = driver of the fetch stage (pipeline/testbench), slave = fetch_pipe.
interface fetch_pipe_if #(
  parameter int AW = 10
);
  logic          stall_i;
  logic          bubble_i;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;

  logic          d_valid;
  logic [2:0]    d_stat;
  logic [3:0]    d_icode;
  logic [3:0]    d_ifun;
  logic [3:0]    d_rA;
  logic [3:0]    d_rB;
  logic [63:0]   d_valC;
  logic [63:0]   d_valP;
  logic [63:0]   d_pc;
  logic [63:0]   pred_pc;
  logic          halted;

  modport master (
    output stall_i, bubble_i, redirect_valid, redirect_pc, ld_en, ld_addr, ld_data,
    input  d_valid, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_pc,
    input  pred_pc, halted
  );

  modport slave (
    input  stall_i, bubble_i, redirect_valid, redirect_pc, ld_en, ld_addr, ld_data,
    output d_valid, d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_pc,
    output pred_pc, halted
  );
endinterface

// File: rtl/fetch_pipe.sv
// fetch_pipe: Y86-64 pipelined fetch stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_pipe_if.slave -- control in, imem load in, F/D out
// Byte-addressed loadable imem, PC select (redirect or predicted), decode and
// validation, next-PC prediction, stallable/bubble-able F/D register, and a
// RUN/HALTED machine that stops fetch after a non-AOK instruction.
module fetch_pipe #(
  parameter int          IMEM_BYTES     = 1024,
  parameter logic [63:0] RESET_PC       = 64'd0,
  parameter bit          BIG_ENDIAN_IMM = 1'b1
) (
  input logic         clk,
  input logic         reset,
  fetch_pipe_if.slave bus
);
  localparam int AW = $clog2(IMEM_BYTES);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] pc;
  } fd_t;

  localparam fd_t FD_BUBBLE = '{valid: 1'b0, stat: S_AOK, icode: 4'h1, ifun: 4'h0,
                                ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0, pc: 64'd0};

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  fd_t         fd_q, fd_d, f_rec;
  logic [63:0] pred_q, pred_d;

  // Instruction memory: async read, write visible from the next cycle, so a
  // same-cycle fetch of a byte being loaded sees the old value.
  logic [7:0] mem [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (bus.ld_en && (32'(bus.ld_addr) < 32'(IMEM_BYTES)))
      mem[bus.ld_addr] <= bus.ld_data;
  end

  logic [63:0] f_pc;
  logic [7:0]  fb [10];

  assign f_pc = bus.redirect_valid ? bus.redirect_pc : pred_q;

  // Up to 10 instruction bytes; bytes past the end of memory read as 0 (the
  // instruction is flagged ADR in that case anyway).
  for (genvar i = 0; i < 10; i++) begin : g_byte
    logic [63:0] addr;
    assign addr  = f_pc + 64'(i);
    assign fb[i] = (addr < 64'(IMEM_BYTES)) ? mem[addr[AW-1:0]] : 8'h00;
  end

  logic [3:0]  icode, ifun, len;
  logic [64:0] fend;
  logic        adr, ins, has_regs, has_imm9, has_imm10, f_aok;
  logic [7:0]  imm_b;
  logic [63:0] valc, valp, pred_next;
  logic [2:0]  stat;

  always_comb begin
    icode = fb[0][7:4];
    ifun  = fb[0][3:0];
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    valp = f_pc + 64'(len);
    // 65-bit end address catches both overrun and 64-bit wrap in one compare.
    fend = {1'b0, f_pc} + 65'(len);
    adr  = fend > 65'(IMEM_BYTES);

    ins = (icode > 4'hB) ||
          ((icode == 4'h6) && (ifun > 4'd3)) ||
          (((icode == 4'h2) || (icode == 4'h7)) && (ifun > 4'd6)) ||
          (!(icode inside {4'h2, 4'h6, 4'h7}) && (ifun != 4'h0));

    has_regs  = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    has_imm9  = icode inside {4'h7, 4'h8};
    has_imm10 = icode inside {4'h3, 4'h4, 4'h5};

    valc  = '0;
    imm_b = '0;
    for (int k = 0; k < 8; k++) begin
      imm_b = has_imm9 ? fb[k+1] : fb[k+2];
      if (BIG_ENDIAN_IMM) valc[8*(7-k) +: 8] = imm_b;
      else                valc[8*k +: 8]     = imm_b;
    end
    if (!(has_imm9 || has_imm10)) valc = '0;

    if (adr)                 stat = S_ADR;
    else if (ins)            stat = S_INS;
    else if (icode == 4'h0)  stat = S_HLT;
    else                     stat = S_AOK;
    f_aok = (stat == S_AOK);

    pred_next = (f_aok && has_imm9) ? valc : valp;

    f_rec       = FD_BUBBLE;
    f_rec.valid = 1'b1;
    f_rec.stat  = stat;
    f_rec.valp  = valp;
    f_rec.pc    = f_pc;
    if (!adr) begin
      f_rec.icode = icode;
      f_rec.ifun  = ifun;
      f_rec.ra    = has_regs ? fb[1][7:4] : 4'hF;
      f_rec.rb    = has_regs ? fb[1][3:0] : 4'hF;
      f_rec.valc  = valc;
    end
  end

  // Redirect always fetches (and is the only way out of HALTED); otherwise
  // HALTED feeds bubbles, and in RUN bubble beats stall.
  always_comb begin
    fd_d    = fd_q;
    pred_d  = pred_q;
    state_d = state_q;
    if (bus.redirect_valid || (state_q == RUN && !bus.bubble_i && !bus.stall_i)) begin
      fd_d    = f_rec;
      if (f_aok) pred_d = pred_next;
      state_d = f_aok ? RUN : HALTED;
    end else if (state_q == HALTED || bus.bubble_i) begin
      fd_d = FD_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q    <= FD_BUBBLE;
      pred_q  <= RESET_PC;
      state_q <= RUN;
    end else begin
      fd_q    <= fd_d;
      pred_q  <= pred_d;
      state_q <= state_d;
    end
  end

  assign bus.d_valid = fd_q.valid;
  assign bus.d_stat  = fd_q.stat;
  assign bus.d_icode = fd_q.icode;
  assign bus.d_ifun  = fd_q.ifun;
  assign bus.d_rA    = fd_q.ra;
  assign bus.d_rB    = fd_q.rb;
  assign bus.d_valC  = fd_q.valc;
  assign bus.d_valP  = fd_q.valp;
  assign bus.d_pc    = fd_q.pc;
  assign bus.pred_pc = pred_q;
  assign bus.halted  = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed scoreboard bench for fetch_pipe. Two DUTs, one
// big-endian-immediate (main) and one little-endian (immediate byte order).
// Stimulus pushes expected F/D records; one negedge monitor pops/compares
// whenever d_valid is high and also checks requested pred_pc/halted/bubble.
module tb_fetch_pipe;
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
  } rec_t;

  logic clk = 1'b0;
  logic rst, rst_le;
  always #5 clk = ~clk;

  fetch_pipe_if #(.AW(10)) bb ();
  fetch_pipe_if #(.AW(10)) bl ();

  fetch_pipe #(.IMEM_BYTES(1024), .RESET_PC(64'd0), .BIG_ENDIAN_IMM(1'b1)) dut_be (
    .clk(clk), .reset(rst), .bus(bb));
  fetch_pipe #(.IMEM_BYTES(1024), .RESET_PC(64'd0), .BIG_ENDIAN_IMM(1'b0)) dut_le (
    .clk(clk), .reset(rst_le), .bus(bl));

  rec_t q_be[$];
  rec_t q_le[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic        st_chk = 1'b0;
  logic [63:0] st_pred;
  logic        st_halt, st_valid;
  logic        done = 1'b0;
  rec_t        got, exp;

  function automatic rec_t mk(logic [2:0] s, logic [3:0] ic, logic [3:0] fn, logic [3:0] ra,
                              logic [3:0] rb, logic [63:0] vc, logic [63:0] vp, logic [63:0] pc);
    return '{s, ic, fn, ra, rb, vc, vp, pc};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (bb.d_valid) begin
      n_tests++;
      got = '{bb.d_stat, bb.d_icode, bb.d_ifun, bb.d_rA, bb.d_rB, bb.d_valC, bb.d_valP, bb.d_pc};
      if (q_be.size() == 0) begin
        n_fail++;
        $display("FAIL sb_be unexpected record got=%h exp=none", got);
      end else begin
        exp = q_be.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_be pc=%0h got=%h exp=%h", exp.pc, got, exp);
        end
      end
    end
    if (bl.d_valid) begin
      n_tests++;
      got = '{bl.d_stat, bl.d_icode, bl.d_ifun, bl.d_rA, bl.d_rB, bl.d_valC, bl.d_valP, bl.d_pc};
      if (q_le.size() == 0) begin
        n_fail++;
        $display("FAIL sb_le unexpected record got=%h exp=none", got);
      end else begin
        exp = q_le.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_le pc=%0h got=%h exp=%h", exp.pc, got, exp);
        end
      end
    end
    if (st_chk) begin
      n_tests++;
      if (bb.pred_pc !== st_pred) begin
        n_fail++;
        $display("FAIL pred_pc got=%h exp=%h", bb.pred_pc, st_pred);
      end
      n_tests++;
      if (bb.halted !== st_halt) begin
        n_fail++;
        $display("FAIL halted got=%b exp=%b", bb.halted, st_halt);
      end
      n_tests++;
      if (bb.d_valid !== st_valid) begin
        n_fail++;
        $display("FAIL d_valid got=%b exp=%b", bb.d_valid, st_valid);
      end
      if (!st_valid) begin
        n_tests++;
        got = '{bb.d_stat, bb.d_icode, bb.d_ifun, bb.d_rA, bb.d_rB, bb.d_valC, bb.d_valP, bb.d_pc};
        exp = mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0);
        if (got !== exp) begin
          n_fail++;
          $display("FAIL bubble_val got=%h exp=%h", got, exp);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (q_be.size() != 0) begin
        n_fail++;
        $display("FAIL sb_be_drain left=%0d exp=0", q_be.size());
      end
      n_tests++;
      if (q_le.size() != 0) begin
        n_fail++;
        $display("FAIL sb_le_drain left=%0d exp=0", q_le.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic step();
    st_chk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input logic [63:0] p, input logic h, input logic v);
    st_pred  = p;
    st_halt  = h;
    st_valid = v;
    st_chk   = 1'b1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    bb.ld_en = 1'b1; bb.ld_addr = a[9:0]; bb.ld_data = d;
    bl.ld_en = 1'b1; bl.ld_addr = a[9:0]; bl.ld_data = d;
    step();
    bb.ld_en = 1'b0;
    bl.ld_en = 1'b0;
  endtask

  task automatic load_zeros(input int a, input int n);
    for (int i = 0; i < n; i++) load(a + i, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    expect_st(64'd0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b1; rst_le = 1'b1;
    bb.stall_i = 0; bb.bubble_i = 0; bb.redirect_valid = 0; bb.redirect_pc = '0;
    bb.ld_en = 0; bb.ld_addr = '0; bb.ld_data = '0;
    bl.stall_i = 0; bl.bubble_i = 0; bl.redirect_valid = 0; bl.redirect_pc = '0;
    bl.ld_en = 0; bl.ld_addr = '0; bl.ld_data = '0;
    repeat (2) step();
    expect_st(64'd0, 1'b0, 1'b0);   // reset state
    step();

    // OPq, nop, halt from reset
    load(0, 8'h60); load(1, 8'h23); load(2, 8'h10); load(3, 8'h00);
    q_be.push_back(mk(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd2, 64'd0));
    q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd3, 64'd2));
    q_be.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd4, 64'd3));
    rst = 1'b0;
    step(); expect_st(64'd2, 1'b0, 1'b1);
    step(); expect_st(64'd3, 1'b0, 1'b1);
    step(); expect_st(64'd3, 1'b1, 1'b1);
    step(); expect_st(64'd3, 1'b1, 1'b0);
    step(); expect_st(64'd3, 1'b1, 1'b0);
    do_reset();                        // reset while halted

    // irmovq, both immediate byte orders, then halt at 10
    load(0, 8'h30); load(1, 8'hF2); load_zeros(2, 7); load(9, 8'h11); load(10, 8'h00);
    q_be.push_back(mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h11, 64'd10, 64'd0));
    q_be.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd10));
    q_le.push_back(mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h1100000000000000, 64'd10, 64'd0));
    q_le.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd10));
    rst = 1'b0; rst_le = 1'b0;
    step(); expect_st(64'd10, 1'b0, 1'b1);
    step(); expect_st(64'd10, 1'b1, 1'b1);
    step(); expect_st(64'd10, 1'b1, 1'b0);
    rst_le = 1'b1;
    do_reset();

    // jxx predicted taken to 0x20, corrected by redirect to 9
    load(0, 8'h70); load_zeros(1, 7); load(8, 8'h20); load(9, 8'h10); load(10, 8'h00);
    q_be.push_back(mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'd9, 64'd0));
    q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, 64'd9));
    q_be.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd10));
    rst = 1'b0;
    step(); expect_st(64'h20, 1'b0, 1'b1);
    bb.redirect_valid = 1'b1; bb.redirect_pc = 64'd9;
    step(); expect_st(64'd10, 1'b0, 1'b1);
    bb.redirect_valid = 1'b0;
    step(); expect_st(64'd10, 1'b1, 1'b1);
    step(); expect_st(64'd10, 1'b1, 1'b0);
    do_reset();

    // ADR at end of memory, halted ignores stall, redirect (over stall) recovers
    load(1020, 8'h30); load(1021, 8'hF2); load(1022, 8'h00); load(1023, 8'h00);
    load(0, 8'h10); load(1, 8'h00);
    q_be.push_back(mk(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1030, 64'd1020));
    q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0));
    q_be.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2, 64'd1));
    rst = 1'b0; bb.redirect_valid = 1'b1; bb.redirect_pc = 64'd1020;
    step(); expect_st(64'd0, 1'b1, 1'b1);
    bb.redirect_valid = 1'b0;
    step(); expect_st(64'd0, 1'b1, 1'b0);
    bb.stall_i = 1'b1;
    step(); expect_st(64'd0, 1'b1, 1'b0);
    bb.redirect_valid = 1'b1; bb.redirect_pc = 64'd0;
    step(); expect_st(64'd1, 1'b0, 1'b1);
    bb.redirect_valid = 1'b0; bb.stall_i = 1'b0;
    step(); expect_st(64'd1, 1'b1, 1'b1);
    do_reset();

    // OPq ifun 3 ok, ifun 7 INS, then redirect onto C0 (INS)
    load(0, 8'h63); load(1, 8'h01); load(2, 8'h67); load(3, 8'h01); load(4, 8'hC0);
    q_be.push_back(mk(3'd1, 4'h6, 4'h3, 4'h0, 4'h1, 64'd0, 64'd2, 64'd0));
    q_be.push_back(mk(3'd4, 4'h6, 4'h7, 4'h0, 4'h1, 64'd0, 64'd4, 64'd2));
    q_be.push_back(mk(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd5, 64'd4));
    rst = 1'b0;
    step(); expect_st(64'd2, 1'b0, 1'b1);
    step(); expect_st(64'd2, 1'b1, 1'b1);
    bb.redirect_valid = 1'b1; bb.redirect_pc = 64'd4;
    step(); expect_st(64'd2, 1'b1, 1'b1);
    bb.redirect_valid = 1'b0;
    step(); expect_st(64'd2, 1'b1, 1'b0);
    do_reset();

    // stall 2 cycles, bubble 1 cycle over a nop stream
    for (int i = 0; i < 5; i++) load(i, 8'h10);
    load(5, 8'h00);
    q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0));
    for (int i = 0; i < 3; i++)
      q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd2, 64'd1));
    for (int i = 2; i < 5; i++)
      q_be.push_back(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), 64'(i)));
    q_be.push_back(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd6, 64'd5));
    rst = 1'b0;
    step(); expect_st(64'd1, 1'b0, 1'b1);
    step(); expect_st(64'd2, 1'b0, 1'b1);
    bb.stall_i = 1'b1;
    step(); expect_st(64'd2, 1'b0, 1'b1);
    step(); expect_st(64'd2, 1'b0, 1'b1);
    bb.stall_i = 1'b0; bb.bubble_i = 1'b1;
    step(); expect_st(64'd2, 1'b0, 1'b0);
    bb.bubble_i = 1'b0;
    step(); expect_st(64'd3, 1'b0, 1'b1);
    step(); expect_st(64'd4, 1'b0, 1'b1);
    step(); expect_st(64'd5, 1'b0, 1'b1);
    step(); expect_st(64'd5, 1'b1, 1'b1);
    bb.stall_i = 1'b1;                 // reset beats stall while halted
    do_reset();
    bb.stall_i = 1'b0;

    step();
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("FAIL monitor_end did not finish");
    $fatal(1);
  end
endmodule
